// File: rtl/srlvec_fifo.sv
// Shallow valid/ready FIFO whose storage is a vector of 32-tap shift registers (SRLC32E style),
// followed by a registered output stage so the combinational tap mux never drives downstream logic.

module srlvec #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [4:0]       a,
  input  logic [NBITS-1:0] din,
  output logic [NBITS-1:0] dout
);

  localparam int unsigned NTAPS = 32;

  logic [NBITS-1:0] taps [NTAPS];

  // Shift chain has no reset, matching the SRL primitive; tap 0 holds the newest word.
  always_ff @(posedge clk) begin
    if (ce) begin
      taps[0] <= din;
      for (int i = 1; i < int'(NTAPS); i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[a];

endmodule

module srlvec_fifo #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AFULL = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [NBITS-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [5:0]       count,
  output logic             prog_full
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic [CW-1:0]    srl_cnt;
  logic [CW-1:0]    srl_cnt_next;
  logic [CW-1:0]    count_next;
  logic             wr_c;
  logic             load_c;
  logic             m_valid_next;
  logic             s_ready_next;
  logic             prog_full_next;
  logic [AW-1:0]    srl_a_c;
  logic [NBITS-1:0] srl_dout_c;

  srlvec #(
    .NBITS (NBITS)
  ) u_srlvec (
    .clk  (clk),
    .ce   (wr_c),
    .a    (srl_a_c),
    .din  (s_data),
    .dout (srl_dout_c)
  );

  // The oldest word sits at srl_cnt-1; the read is taken pre-shift, so a
  // same-edge write and load leave the occupancy unchanged.
  always_comb begin
    wr_c           = s_valid & s_ready;
    load_c         = (srl_cnt != '0) & (~m_valid | m_ready);
    srl_a_c        = '0;
    m_valid_next   = m_valid;
    if (srl_cnt != '0) begin
      srl_a_c = AW'(srl_cnt - CW'(1));
    end
    if (load_c) begin
      m_valid_next = 1'b1;
    end else if (m_ready) begin
      m_valid_next = 1'b0;
    end
    srl_cnt_next   = srl_cnt + CW'(wr_c) - CW'(load_c);
    s_ready_next   = (srl_cnt_next < CW'(DEPTH));
    count_next     = srl_cnt_next + CW'(m_valid_next);
    prog_full_next = (count_next >= CW'(AFULL));
  end

  // Control state only; the SRL contents are left untouched by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_cnt   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      s_ready   <= 1'b0;
      count     <= '0;
      prog_full <= 1'b0;
    end else begin
      srl_cnt   <= srl_cnt_next;
      m_valid   <= m_valid_next;
      s_ready   <= s_ready_next;
      count     <= count_next;
      prog_full <= prog_full_next;
      if (load_c) begin
        m_data <= srl_dout_c;
      end
    end
  end

endmodule

// File: tb/tb_srlvec_fifo.sv
// Directed and randomized-backpressure bench for srlvec_fifo: a DEPTH=32 instance for the
// directed scenarios and a DEPTH=4/AFULL=3 instance for the scoreboard run.
module tb_srlvec_fifo;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_sdata;
  logic       a_svalid;
  logic       a_sready;
  logic [7:0] a_mdata;
  logic       a_mvalid;
  logic       a_mready;
  logic [5:0] a_count;
  logic       a_pf;

  logic [7:0] b_sdata;
  logic       b_svalid;
  logic       b_sready;
  logic [7:0] b_mdata;
  logic       b_mvalid;
  logic       b_mready;
  logic [5:0] b_count;
  logic       b_pf;

  int checks = 0;
  int errors = 0;

  srlvec_fifo #(.NBITS(8), .DEPTH(32), .AFULL(28)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_data(a_sdata), .s_valid(a_svalid), .s_ready(a_sready),
    .m_data(a_mdata), .m_valid(a_mvalid), .m_ready(a_mready),
    .count(a_count), .prog_full(a_pf)
  );

  srlvec_fifo #(.NBITS(8), .DEPTH(4), .AFULL(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready),
    .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready),
    .count(b_count), .prog_full(b_pf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    checks++;
    if (a_sready !== 1'b0) begin errors++; $display("FAIL %s s_ready got %b want 0", tag, a_sready); end
    checks++;
    if (a_mvalid !== 1'b0) begin errors++; $display("FAIL %s m_valid got %b want 0", tag, a_mvalid); end
    checks++;
    if (a_mdata !== 8'h00) begin errors++; $display("FAIL %s m_data got %h want 00", tag, a_mdata); end
    checks++;
    if (a_count !== 6'd0) begin errors++; $display("FAIL %s count got %0d want 0", tag, a_count); end
    checks++;
    if (a_pf !== 1'b0) begin errors++; $display("FAIL %s prog_full got %b want 0", tag, a_pf); end
  endtask

  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_sready !== 1'b0) begin errors++; $display("FAIL %s s_ready_before_edge got %b want 0", tag, a_sready); end
    tick();
    checks++;
    if (a_sready !== 1'b1) begin errors++; $display("FAIL %s s_ready_after_edge got %b want 1", tag, a_sready); end
    checks++;
    if (a_mvalid !== 1'b0) begin errors++; $display("FAIL %s m_valid_after_edge got %b want 0", tag, a_mvalid); end
    checks++;
    if (a_count !== 6'd0) begin errors++; $display("FAIL %s count_after_edge got %0d want 0", tag, a_count); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_a_zero("reset_initial");
    tick();
    tick();
    check_a_zero("reset_held");
    release_reset("reset_release");
  endtask

  task automatic test_mid_reset();
    a_mready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_sdata  = 8'(8'h30 + i);
      a_svalid = 1'b1;
      tick();
    end
    a_svalid = 1'b0;
    tick();
    tick();
    checks++;
    if (a_count !== 6'd10) begin errors++; $display("FAIL midreset_count got %0d want 10", a_count); end
    checks++;
    if (a_mvalid !== 1'b1) begin errors++; $display("FAIL midreset_mvalid got %b want 1", a_mvalid); end
    #2 rst_n = 1'b0;
    #1;
    check_a_zero("midreset_async");
    tick();
    release_reset("midreset_release");
  endtask

  task automatic test_latency();
    a_mready = 1'b0;
    a_sdata  = 8'hA5;
    a_svalid = 1'b1;
    tick();
    a_svalid = 1'b0;
    checks++;
    if (a_mvalid !== 1'b0) begin errors++; $display("FAIL latency_edgeN_mvalid got %b want 0", a_mvalid); end
    checks++;
    if (a_count !== 6'd1) begin errors++; $display("FAIL latency_edgeN_count got %0d want 1", a_count); end
    tick();
    checks++;
    if (a_mvalid !== 1'b1) begin errors++; $display("FAIL latency_edgeN1_mvalid got %b want 1", a_mvalid); end
    checks++;
    if (a_mdata !== 8'hA5) begin errors++; $display("FAIL latency_edgeN1_mdata got %h want a5", a_mdata); end
    a_mready = 1'b1;
    tick();
    a_mready = 1'b0;
    checks++;
    if (a_mvalid !== 1'b0 || a_count !== 6'd0) begin
      errors++; $display("FAIL latency_pop mvalid=%b count=%0d want 0 0", a_mvalid, a_count);
    end
  endtask

  task automatic test_fill();
    int acc;
    acc      = 0;
    a_mready = 1'b0;
    for (int c = 0; c < 41; c++) begin
      a_sdata  = 8'(acc);
      a_svalid = 1'b1;
      if (a_sready === 1'b1) acc++;
      tick();
      checks++;
      if (a_count !== 6'(acc)) begin errors++; $display("FAIL fill_count c=%0d got %0d want %0d", c, a_count, acc); end
      checks++;
      if (a_pf !== (acc >= 28)) begin errors++; $display("FAIL fill_prog_full c=%0d got %b want %b", c, a_pf, acc >= 28); end
    end
    checks++;
    if (acc != 33) begin errors++; $display("FAIL fill_accepted got %0d want 33", acc); end
    checks++;
    if (a_sready !== 1'b0) begin errors++; $display("FAIL fill_sready got %b want 0", a_sready); end
    checks++;
    if (a_mvalid !== 1'b1 || a_mdata !== 8'h00) begin
      errors++; $display("FAIL fill_head mvalid=%b mdata=%h want 1 00", a_mvalid, a_mdata);
    end
  endtask

  task automatic test_full_push_pop();
    a_sdata  = 8'hEE;
    a_svalid = 1'b1;
    a_mready = 1'b1;
    tick();
    a_svalid = 1'b0;
    a_mready = 1'b0;
    checks++;
    if (a_count !== 6'd32) begin errors++; $display("FAIL fullpp_count got %0d want 32", a_count); end
    checks++;
    if (a_sready !== 1'b1) begin errors++; $display("FAIL fullpp_sready got %b want 1", a_sready); end
    checks++;
    if (a_mvalid !== 1'b1 || a_mdata !== 8'h01) begin
      errors++; $display("FAIL fullpp_head mvalid=%b mdata=%h want 1 01", a_mvalid, a_mdata);
    end
  endtask

  task automatic test_drain();
    a_mready = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      checks++;
      if (a_mvalid !== 1'b1 || a_mdata !== 8'(i)) begin
        errors++; $display("FAIL drain_word i=%0d mvalid=%b mdata=%h want 1 %h", i, a_mvalid, a_mdata, 8'(i));
      end
      tick();
    end
    a_mready = 1'b0;
    checks++;
    if (a_mvalid !== 1'b0 || a_count !== 6'd0 || a_pf !== 1'b0) begin
      errors++; $display("FAIL drain_empty mvalid=%b count=%0d pf=%b want 0 0 0", a_mvalid, a_count, a_pf);
    end
  endtask

  // One word in the SRL plus one in the output register in steady state.
  task automatic test_streaming();
    a_svalid = 1'b1;
    a_mready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      a_sdata = 8'(c);
      checks++;
      if (a_sready !== 1'b1) begin errors++; $display("FAIL stream_sready c=%0d got %b want 1", c, a_sready); end
      tick();
      if (c >= 1) begin
        checks++;
        if (a_mvalid !== 1'b1 || a_mdata !== 8'(c - 1) || a_count !== 6'd2) begin
          errors++;
          $display("FAIL stream_word c=%0d mvalid=%b mdata=%h count=%0d want 1 %h 2",
                   c, a_mvalid, a_mdata, a_count, 8'(c - 1));
        end
      end
    end
    a_svalid = 1'b0;
    tick();
    checks++;
    if (a_mvalid !== 1'b1 || a_mdata !== 8'(999)) begin
      errors++; $display("FAIL stream_last mvalid=%b mdata=%h want 1 %h", a_mvalid, a_mdata, 8'(999));
    end
    tick();
    a_mready = 1'b0;
    checks++;
    if (a_mvalid !== 1'b0 || a_count !== 6'd0) begin
      errors++; $display("FAIL stream_empty mvalid=%b count=%0d want 0 0", a_mvalid, a_count);
    end
  endtask

  task automatic test_random_backpressure();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic [7:0] held_data;
    logic       wr, rd, held;
    int         tx, rx, cyc;
    tx  = 0;
    rx  = 0;
    cyc = 0;
    while (rx < 10000 && cyc < 60000) begin
      b_svalid = (tx < 10000) && ($urandom_range(0, 3) != 0);
      b_sdata  = 8'(tx);
      b_mready = ($urandom_range(0, 2) != 0);
      #1;
      wr        = b_svalid & b_sready;
      rd        = b_mvalid & b_mready;
      held      = b_mvalid & ~b_mready;
      held_data = b_mdata;
      if (rd) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_pop_empty rx=%0d got %h want nothing", rx, b_mdata);
        end else begin
          exp = q.pop_front();
          if (b_mdata !== exp) begin
            errors++; $display("FAIL rand_order rx=%0d got %h want %h", rx, b_mdata, exp);
          end
        end
        rx++;
      end
      if (wr) begin
        q.push_back(8'(tx));
        tx++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (held) begin
        checks++;
        if (b_mvalid !== 1'b1 || b_mdata !== held_data) begin
          errors++; $display("FAIL rand_hold cyc=%0d mvalid=%b mdata=%h want 1 %h", cyc, b_mvalid, b_mdata, held_data);
        end
      end
      checks++;
      if (b_count !== 6'(q.size()) || b_pf !== (q.size() >= 3) || q.size() > 5) begin
        errors++;
        $display("FAIL rand_count cyc=%0d count=%0d pf=%b want %0d %b", cyc, b_count, b_pf, q.size(), q.size() >= 3);
      end
    end
    b_svalid = 1'b0;
    b_mready = 1'b0;
    checks++;
    if (rx != 10000) begin errors++; $display("FAIL rand_timeout received %0d want 10000", rx); end
  endtask

  initial begin
    rst_n    = 1'b1;
    a_sdata  = '0; a_svalid = 1'b0; a_mready = 1'b0;
    b_sdata  = '0; b_svalid = 1'b0; b_mready = 1'b0;
    test_reset();
    test_mid_reset();
    test_latency();
    test_fill();
    test_full_push_pop();
    test_drain();
    test_streaming();
    test_random_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
